// File: rtl/vga_pixel_out.sv
// vga_pixel_out: display output stage. It decodes the timer's column/row counts
// into sync and blanking, fetches each visible pixel from the frame buffer with
// a one-clk request, and drives RGB332 colour aligned with sync and blank. All
// outputs lag the counts that produced them by one pixel strobe.
module vga_pixel_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        enable,
  input  logic        pixel_clk,
  input  logic [9:0]  col,
  input  logic [9:0]  row,
  input  logic [7:0]  rd_data,
  input  logic        rd_valid,
  input  logic        clr_underrun,
  output logic        rd_req,
  output logic [19:0] rd_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        frame_start,
  output logic        underrun
);

  // Combinational decode of the current counts
  logic        act;
  logic        hs_n;
  logic        vs_n;
  logic        first;
  logic [19:0] addr_next;

  // Pipeline control
  logic stage;
  logic bypass;
  logic underrun_set;

  // Stage 0 registers
  logic        rd_req_reg;
  logic [19:0] rd_addr_reg;
  logic        act0_reg;
  logic        hs0_reg;
  logic        vs0_reg;
  logic        first0_reg;

  // Read-return buffer
  logic       outst_reg;
  logic       buf_valid_reg;
  logic [7:0] buf_reg;

  // Stage 1 (pin) registers
  logic       hsync_reg;
  logic       vsync_reg;
  logic       blank_n_reg;
  logic       frame_start_reg;
  logic       underrun_reg;
  logic [7:0] rgb_reg;

  // Decode visible area, sync windows and frame-buffer address from the counts.
  // Counts past the frame size fall outside every window: blank, sync inactive.
  always_comb begin
    act       = (col < 10'(H_ACTIVE)) && (row < 10'(V_ACTIVE));
    hs_n      = !((col >= 10'(H_ACTIVE + H_FP)) &&
                  (col <= 10'(H_ACTIVE + H_FP + H_SYNC - 1)));
    vs_n      = !((row >= 10'(V_ACTIVE + V_FP)) &&
                  (row <= 10'(V_ACTIVE + V_FP + V_SYNC - 1)));
    first     = (col == 10'd0) && (row == 10'd0);
    addr_next = 20'(row) * 20'(H_ACTIVE) + 20'(col);
  end

  assign stage        = pixel_clk && enable;
  // A return arriving on the very strobe that outputs the pixel is used directly.
  assign bypass       = rd_valid && outst_reg;
  assign underrun_set = stage && act0_reg && !buf_valid_reg && !bypass;

  // Stage 0: register decoded flags and issue the read for visible pixels.
  // rd_req_reg holds while disabled so a request pending across an enable
  // drop is still issued once the block resumes.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rd_req_reg  <= 1'b0;
      rd_addr_reg <= 20'd0;
      act0_reg    <= 1'b0;
      hs0_reg     <= 1'b1;
      vs0_reg     <= 1'b1;
      first0_reg  <= 1'b0;
    end else begin
      if (enable) rd_req_reg <= stage && act;
      if (stage) begin
        act0_reg   <= act;
        hs0_reg    <= hs_n;
        vs0_reg    <= vs_n;
        first0_reg <= first;
        if (act) rd_addr_reg <= addr_next;
      end
    end
  end

  // Track the single outstanding request and capture its return data.
  // Each strobe retires the previous request (consumed or expired) and
  // opens a new one if the new pixel is visible; returns with nothing
  // outstanding are ignored.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      outst_reg     <= 1'b0;
      buf_valid_reg <= 1'b0;
      buf_reg       <= 8'd0;
    end else if (stage) begin
      outst_reg     <= act;
      buf_valid_reg <= 1'b0;
    end else if (bypass) begin
      buf_reg       <= rd_data;
      buf_valid_reg <= 1'b1;
      outst_reg     <= 1'b0;
    end
  end

  // Stage 1: drive sync, blank and colour for the pixel registered in stage 0.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      blank_n_reg     <= 1'b0;
      rgb_reg         <= 8'd0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= stage && first0_reg;
      if (stage) begin
        hsync_reg   <= hs0_reg;
        vsync_reg   <= vs0_reg;
        blank_n_reg <= act0_reg;
        if (!act0_reg)          rgb_reg <= 8'd0;
        else if (buf_valid_reg) rgb_reg <= buf_reg;
        else if (bypass)        rgb_reg <= rd_data;
        else                    rgb_reg <= 8'd0;
      end
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!n_rst)            underrun_reg <= 1'b0;
    else if (underrun_set) underrun_reg <= 1'b1;
    else if (clr_underrun) underrun_reg <= 1'b0;
  end

  assign rd_req      = rd_req_reg && enable;
  assign rd_addr     = rd_addr_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign blank_n     = blank_n_reg;
  assign red         = rgb_reg[7:5];
  assign green       = rgb_reg[4:2];
  assign blue        = rgb_reg[1:0];
  assign frame_start = frame_start_reg;
  assign underrun    = underrun_reg;

endmodule

// File: tb/tb_vga_pixel_out.sv
// tb_vga_pixel_out: randomized strobe spacing and read-return latency, with a
// scoreboard of expected pixel outputs computed from the display timing rules.
module tb_vga_pixel_out;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        enable = 1'b1;
  logic        pixel_clk = 1'b0;
  logic [9:0]  col = '0;
  logic [9:0]  row = '0;
  logic [7:0]  rd_data = '0;
  logic        rd_valid = 1'b0;
  logic        clr_underrun = 1'b0;
  logic        rd_req;
  logic [19:0] rd_addr;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [2:0]  red;
  logic [2:0]  green;
  logic [1:0]  blue;
  logic        frame_start;
  logic        underrun;

  vga_pixel_out dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .pixel_clk(pixel_clk),
    .col(col), .row(row), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_underrun(clr_underrun), .rd_req(rd_req), .rd_addr(rd_addr),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .red(red),
    .green(green), .blue(blue), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hs;
    logic       vs;
    logic       blank;
    logic [7:0] rgb;
    logic       first;
    logic       withheld;
  } exp_t;

  typedef struct {
    int          d;      // return delay in clks after rd_req; -1 = never
    logic [7:0]  data;
    logic [19:0] addr;
  } pol_t;

  exp_t sb_q[$];
  pol_t pol_q[$];
  int   checks = 0;
  int   fails = 0;
  int   n_req = 0;
  int   exp_req = 0;
  int   n_fs = 0;
  int   exp_fs = 0;
  logic und_m = 1'b0;
  logic [19:0] last_addr = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t idle_rec();
    exp_t e;
    e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0; e.rgb = 8'd0;
    e.first = 1'b0; e.withheld = 1'b0;
    return e;
  endfunction

  // Reset for 3 clks and check the reset state of every output
  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0; enable = 1'b1; pixel_clk = 1'b0; clr_underrun = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_blank_n", 32'(blank_n), 32'd0);
    check("rst_rgb", 32'({red, green, blue}), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    n_rst = 1'b1;
    exp_req -= pol_q.size();
    pol_q.delete();
    sb_q.delete();
    sb_q.push_back(idle_rec());
    last_addr = '0;
  endtask

  // One pixel strobe. mode 0: normal return, 1: withheld, 2: late return.
  // dis: drop enable for 10 clks right after the strobe.
  task automatic pix(input int c, input int r, input int mode, input bit dis);
    int   gap;
    logic vis;
    exp_t e;
    pol_t p;
    gap = $urandom_range(1, 3);
    vis = (c < 640) && (r < 480);
    @(negedge clk);
    enable = 1'b1; pixel_clk = 1'b1;
    col = 10'(c); row = 10'(r);
    p.data = 8'($urandom);
    p.addr = 20'(r * 640 + c);
    p.d = (mode == 1) ? -1 : (mode == 2) ? gap : int'($urandom_range(0, gap - 1));
    e.hs = !(c >= 656 && c <= 751);
    e.vs = !(r >= 490 && r <= 491);
    e.blank = vis;
    e.first = (c == 0) && (r == 0);
    e.withheld = vis && (mode != 0);
    e.rgb = (vis && mode == 0) ? p.data : 8'd0;
    sb_q.push_back(e);
    if (e.first) exp_fs++;
    if (vis) begin
      pol_q.push_back(p);
      exp_req++;
      last_addr = p.addr;
    end
    if (dis) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        enable = 1'b0;
        pixel_clk = 1'($urandom_range(0, 1));
        #1;
        check("dis_rd_req", 32'(rd_req), 32'd0);
        check("dis_rd_addr", 32'(rd_addr), 32'(last_addr));
      end
    end
    for (int i = 1; i < gap; i++) begin
      @(negedge clk);
      enable = 1'b1; pixel_clk = 1'b0;
    end
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    pixel_clk = 1'b0; clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
  endtask

  function automatic bit keep_col(input int c);
    return c < 5 || (c >= 637 && c <= 643) || (c >= 654 && c <= 658) ||
           (c >= 749 && c <= 753) || c >= 797;
  endfunction

  // Frame-buffer model: answers each rd_req after the chosen delay
  initial begin
    int         resp_cnt;
    logic [7:0] resp_data;
    pol_t       p;
    resp_cnt = 0;
    resp_data = '0;
    forever begin
      @(negedge clk);
      rd_valid = 1'b0;
      rd_data = 8'($urandom);
      if (!n_rst) begin
        resp_cnt = 0;
      end else begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            rd_valid = 1'b1; rd_data = resp_data;
          end
        end
        if (rd_req) begin
          n_req++;
          if (pol_q.size() == 0) begin
            check("rd_req_unexpected", 32'd1, 32'd0);
          end else begin
            p = pol_q.pop_front();
            check("rd_addr", 32'(rd_addr), 32'(p.addr));
            if (p.d == 0) begin
              rd_valid = 1'b1; rd_data = p.data;
            end else if (p.d > 0) begin
              resp_cnt = p.d; resp_data = p.data;
            end
          end
        end
      end
    end
  end

  // Monitor: each enabled strobe moves one pixel to the pins
  initial begin
    logic fire, clr, rst;
    exp_t e;
    forever begin
      @(posedge clk);
      fire = pixel_clk && enable && n_rst;
      clr = clr_underrun;
      rst = !n_rst;
      @(negedge clk);
      if (frame_start === 1'b1) n_fs++;
      if (rst) begin
        und_m = 1'b0;
      end else begin
        if (clr) und_m = 1'b0;
        if (fire) begin
          if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            if (e.withheld) und_m = 1'b1;
            check("hsync", 32'(hsync), 32'(e.hs));
            check("vsync", 32'(vsync), 32'(e.vs));
            check("blank_n", 32'(blank_n), 32'(e.blank));
            check("rgb", 32'({red, green, blue}), 32'(e.rgb));
            check("frame_start", 32'(frame_start), 32'(e.first));
          end
        end
        if (fire || clr) check("underrun", 32'(underrun), 32'(und_m));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    for (int c = 0; c < 800; c++) pix(c, 0, 0, 1'b0);
    for (int c = 0; c < 800; c++) pix(c, 1, 0, c == 100);
    for (int c = 0; c < 800; c++) pix(c, 2, (c == 639) ? 2 : 0, 1'b0);
    clr_pulse();
    for (int c = 0; c < 800; c++) pix(c, 3, (c == 5) ? 1 : 0, 1'b0);
    clr_pulse();
    for (int c = 0; c < 22; c++) pix(c, 4, 0, 1'b0);
    do_reset();
    for (int c = 22; c < 800; c++) pix(c, 4, 0, 1'b0);
    for (int r = 476; r < 495; r++)
      for (int c = 0; c < 800; c++)
        if (keep_col(c)) pix(c, r, 0, 1'b0);
    for (int r = 522; r < 525; r++)
      for (int c = 795; c < 800; c++) pix(c, r, 0, 1'b0);
    pix(900, 600, 0, 1'b0);
    pix(1023, 1023, 0, 1'b0);
    for (int c = 0; c < 6; c++) pix(c, 0, 0, 1'b0);
    pix(700, 0, 0, 1'b0);
    repeat (6) @(negedge clk);
    check("req_count", 32'(n_req), 32'(exp_req));
    check("frame_start_count", 32'(n_fs), 32'(exp_fs));
    check("scoreboard_left", 32'(sb_q.size()), 32'd1);
    check("pending_req_left", 32'(pol_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_pixel_out.md
# vga_pixel_out

Display output stage fed by the timer top: consumes the pixel strobe and the column/row counts, generates registered VGA sync and blanking, fetches each visible pixel from the frame buffer through a request/valid handshake, and drives RGB332 colour to the DAC pins. Sync, blank and colour leave the block aligned on the same pixel strobe, one pixel period after the counts that produced them.

## Interface
- H_ACTIVE, 640, visible columns
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- V_ACTIVE, 480, visible rows
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- clk  in  1  system clock; the only clock.
- n_rst  in  1  reset, synchronous, active-low.
- enable  in  1  high: block advances; low: all registers hold, rd_req forced 0
- pixel_clk  in  1  one-clk pixel strobe from the clock divider
- col  in  10  current column count (0..799)
- row  in  10  current row count (0..524)
- rd_data  in  8  frame-buffer pixel, RGB332 {r[2:0],g[2:0],b[1:0]}
- rd_valid  in  1  rd_data valid this cycle
- clr_underrun  in  1  clears sticky underrun
- rd_req  out  1  one-clk frame-buffer read request
- rd_addr  out  20  read address, row*H_ACTIVE+col
- hsync, vsync  out  1 each  active-low sync
- blank_n  out  1  high during visible pixels
- red, green  out  3 each; blue  out  2
- frame_start  out  1  one-clk pulse at first pixel of a frame
- underrun  out  1  sticky: a visible pixel was output without data

## Operation
- Decode (combinational, on col/row): act = col<H_ACTIVE && row<V_ACTIVE; hs_n = !(col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]) i.e. low for 656..751; vs_n = !(row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]) i.e. low for 490..491. Out-of-range counts decode as blank, sync inactive.
- Stage 0 (on pixel_clk && enable): register act0, hs0, vs0, first0 = (col==0 && row==0). If act: rd_req=1 for exactly that cycle+1 register, rd_addr = row*H_ACTIVE+col (20-bit, max 307199); request marked outstanding.
- Data buffer: on rd_valid while outstanding, capture rd_data, set buf_valid, clear outstanding. rd_valid with nothing outstanding ignored.
- Stage 1 (next pixel_clk && enable): hsync<=hs0, vsync<=vs0, blank_n<=act0, frame_start pulses 1 clk if first0. If act0 && buf_valid: rgb<=buffer, buf_valid cleared. If act0 && !buf_valid (including rd_valid arriving that same cycle is NOT late—bypass captures it): rgb<=0, underrun<=1, outstanding cleared. If !act0: rgb<=0.
- clr_underrun clears underrun; a new underrun in the same cycle wins (stays 1).

## Timing
- Reset (n_rst low at a clk edge): hsync=1, vsync=1, blank_n=0, rgb=0, rd_req=0, rd_addr=0, frame_start=0, underrun=0, buffer/outstanding cleared. Reset mid-line discards any outstanding request.
- rd_req asserted the clk after the pixel strobe, width 1 clk; rd_addr held until the next request.
- rd_valid accepted from the cycle rd_req is high through the next pixel_clk cycle inclusive; later returns are dropped.
- Output latency: sync/blank/rgb reflect counts sampled one pixel strobe earlier (2 clks with divide-by-2 strobe).
- enable low: no stage advances, outputs frozen, rd_req 0; outstanding request survives and resumes.
- Back-to-back: one request per pixel strobe; no more than one outstanding.

## Test plan
- Reset: hold n_rst low 3 clks mid-frame -> hsync=1, vsync=1, blank_n=0, rgb=0, rd_req=0, underrun=0.
- Line sweep col 0..799, row 0, rd_valid 1 clk after each rd_req with rd_data=col[7:0] -> 640 rd_req pulses, rd_addr 0..639, rgb=col[7:0] one strobe later, hsync low exactly for output of cols 656..751, blank_n low cols 640..799.
- Full frame -> vsync low for rows 490..491 only, frame_start one pulse per frame at col0/row0 output, 307200 requests, last rd_addr 307199.
- Withhold rd_valid for col 5 row 3 -> that pixel rgb=0, underrun=1 sticky; clr_underrun pulse -> 0; late rd_valid ignored.
- rd_valid coincident with the next pixel_clk -> data displayed, no underrun.
- Drop enable for 10 clks mid-line -> outputs/rd_addr frozen, no rd_req; resume continues without skipped or duplicated pixels.
